// File: rtl/wb_common_pkg.sv
// Shared Wishbone encodings and FSM state type for the burst master.
// Optional watchdog is enabled with the WB_BURST_MASTER_TIMEOUT_EN macro.
package wb_common_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_ERR     = 2'b01;
    localparam logic [1:0] STATUS_RTY     = 2'b10;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Single-beat commands use classic cycles; bursts mark the last beat.
    function automatic logic [2:0] beat_cti(input logic single, input logic last);
        if (single)
            return CTI_CLASSIC;
        else if (last)
            return CTI_EOB;
        else
            return CTI_INCR;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Stall watchdog: down-counter reloaded on clear, expires at terminal count.
// Only instantiated when WB_BURST_MASTER_TIMEOUT_EN is defined.
module wb_watchdog #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expire
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LOAD = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = LOAD;
        else if (tick)
            cnt_d = (cnt_q == '0) ? LOAD : cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= LOAD;
        else
            cnt_q <= cnt_d;
    end

    assign expire = tick & ~clear & (cnt_q == '0);

endmodule

// File: rtl/wb_burst_master.sv
// Command-driven Wishbone burst master (incrementing bursts, single outstanding beat).
// Define WB_BURST_MASTER_TIMEOUT_EN to add the stall watchdog (status 11).
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// BUS     | cycle open, beats in flight
// DONE    | one-cycle done pulse with status, bus released
module wb_burst_master
    import wb_common_pkg::*;
#(
    parameter int dw      = 32,
    parameter int aw      = 32,
    parameter int LW      = 8,
    parameter int TIMEOUT = 256
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,

    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [aw-1:0]   cmd_adr,
    input  logic [LW-1:0]   cmd_len,

    input  logic            wdat_valid,
    output logic            wdat_ready,
    input  logic [dw-1:0]   wdat_data,
    input  logic [dw/8-1:0] wdat_sel,

    output logic            rdat_valid,
    output logic [dw-1:0]   rdat_data,

    output logic            done,
    output logic [1:0]      status,

    output logic [aw-1:0]   wb_adr_o,
    output logic [dw-1:0]   wb_dat_o,
    output logic [dw/8-1:0] wb_sel_o,
    output logic            wb_we_o,
    output logic [2:0]      wb_cti_o,
    output logic [1:0]      wb_bte_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    input  logic [dw-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic            wb_rty_i
);

    localparam int SW = dw / 8;
    localparam logic [aw-1:0] ADR_STEP = aw'(SW);

    state_t          state_q, state_d;
    logic            we_q, we_d;
    logic            single_q, single_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [aw-1:0]   adr_q, adr_d;
    logic            loaded_q, loaded_d;
    logic [dw-1:0]   dat_q, dat_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [1:0]      status_q, status_d;

    logic in_bus, stb, last_beat;
    logic err_hit, rty_hit, ack_hit;
    logic wdat_take, expire;

    assign in_bus    = (state_q == ST_BUS);
    assign stb       = in_bus & (~we_q | loaded_q);
    assign last_beat = (cnt_q == '0);

    // Responses are only honoured against an active strobe; err > rty > ack.
    assign err_hit = stb & wb_err_i;
    assign rty_hit = stb & wb_rty_i & ~wb_err_i;
    assign ack_hit = stb & wb_ack_i & ~wb_err_i & ~wb_rty_i;

    assign wdat_ready = in_bus & we_q & ~wb_rst_i & (~loaded_q | (ack_hit & ~last_beat));
    assign wdat_take  = wdat_ready & wdat_valid;

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    logic stall;
    assign stall = stb & ~wb_ack_i & ~wb_err_i & ~wb_rty_i;

    wb_watchdog #(
        .LIMIT (TIMEOUT)
    ) u_watchdog (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clear  (~stall),
        .tick   (stall),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        single_d = single_q;
        cnt_d    = cnt_q;
        adr_d    = adr_q;
        loaded_d = loaded_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        status_d = status_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    we_d     = cmd_we;
                    adr_d    = cmd_adr;
                    cnt_d    = cmd_len;
                    single_d = (cmd_len == '0);
                    loaded_d = 1'b0;
                    dat_d    = '0;
                    sel_d    = '0;
                    status_d = STATUS_OK;
                    state_d  = ST_BUS;
                end
            end
            ST_BUS: begin
                if (wdat_take) begin
                    loaded_d = 1'b1;
                    dat_d    = wdat_data;
                    sel_d    = wdat_sel;
                end else if (ack_hit) begin
                    loaded_d = 1'b0;
                end

                if (err_hit) begin
                    status_d = STATUS_ERR;
                    loaded_d = 1'b0;
                    state_d  = ST_DONE;
                end else if (rty_hit) begin
                    status_d = STATUS_RTY;
                    loaded_d = 1'b0;
                    state_d  = ST_DONE;
                end else if (ack_hit) begin
                    adr_d = adr_q + ADR_STEP;
                    if (last_beat) begin
                        status_d = STATUS_OK;
                        state_d  = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - LW'(1);
                    end
                end else if (expire) begin
                    status_d = STATUS_TIMEOUT;
                    loaded_d = 1'b0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            single_q <= 1'b0;
            cnt_q    <= '0;
            adr_q    <= '0;
            loaded_q <= 1'b0;
            dat_q    <= '0;
            sel_q    <= '0;
            status_q <= STATUS_OK;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            single_q <= single_d;
            cnt_q    <= cnt_d;
            adr_q    <= adr_d;
            loaded_q <= loaded_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            status_q <= status_d;
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign rdat_valid = ack_hit & ~we_q & ~wb_rst_i;
    assign rdat_data  = rdat_valid ? wb_dat_i : '0;
    assign done       = (state_q == ST_DONE);
    assign status     = status_q;

    assign wb_cyc_o = in_bus;
    assign wb_stb_o = stb;
    assign wb_we_o  = in_bus & we_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = in_bus ? (we_q ? sel_q : {SW{1'b1}}) : '0;
    assign wb_cti_o = in_bus ? beat_cti(single_q, last_beat) : CTI_CLASSIC;
    assign wb_bte_o = BTE_LINEAR;

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master with a zero-wait Wishbone slave model.
// Timeout expectations follow WB_BURST_MASTER_TIMEOUT_EN.
module tb_wb_burst_master;

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [7:0]  cmd_len = '0;
    logic        wdat_valid;
    logic        wdat_ready;
    logic [31:0] wdat_data;
    logic [3:0]  wdat_sel;
    logic        rdat_valid;
    logic [31:0] rdat_data;
    logic        done;
    logic [1:0]  status;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_rty_i;

    // slave / source controls, written only by the stimulus block
    logic        slv_en = 1'b1;
    logic        err_mode = 1'b0;
    logic        rty_mode = 1'b0;
    int          err_beat = 0;
    logic        wsrc_on = 1'b0;
    int          wsrc_n = 0;
    logic [31:0] wbase = '0;
    int          stall_at = -1;
    int          stall_len = 0;
    logic        clr = 1'b0;

    // monitor state, written only by the monitor block
    int          beat_cnt, rd_cnt, done_cnt, stb_low, stall_cyc, wsrc_idx, stall_seen;
    logic [31:0] rd_last;
    logic [1:0]  last_status;
    logic        err_prev, cyc_after_err;
    logic [31:0] log_adr [0:15];
    logic [2:0]  log_cti [0:15];
    logic [31:0] mem [0:15];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_burst_master #(
        .dw(32), .aw(32), .LW(8), .TIMEOUT(16)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (wb_rst_i),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_adr    (cmd_adr),
        .cmd_len    (cmd_len),
        .wdat_valid (wdat_valid),
        .wdat_ready (wdat_ready),
        .wdat_data  (wdat_data),
        .wdat_sel   (wdat_sel),
        .rdat_valid (rdat_valid),
        .rdat_data  (rdat_data),
        .done       (done),
        .status     (status),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_we_o    (wb_we_o),
        .wb_cti_o   (wb_cti_o),
        .wb_bte_o   (wb_bte_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i),
        .wb_rty_i   (wb_rty_i)
    );

    logic err_now, rty_now;
    assign err_now  = wb_cyc_o & wb_stb_o & err_mode & (beat_cnt == err_beat);
    assign rty_now  = wb_cyc_o & wb_stb_o & rty_mode;
    assign wb_ack_i = wb_cyc_o & wb_stb_o & slv_en & ~err_now & ~rty_now;
    assign wb_err_i = err_now;
    assign wb_rty_i = rty_now;
    assign wb_dat_i = (wb_adr_o == 32'h100) ? 32'hDEADBEEF : (32'hA5A5_0000 | wb_adr_o);

    logic src_hold;
    assign src_hold   = (wsrc_idx == stall_at) && (stall_seen < stall_len);
    assign wdat_valid = wsrc_on && (wsrc_idx < wsrc_n) && !src_hold;
    assign wdat_data  = wbase + 32'(wsrc_idx) + 32'd1;
    assign wdat_sel   = 4'hF;

    always @(posedge clk) begin
        err_prev <= wb_err_i;
        if (clr) begin
            beat_cnt <= 0; rd_cnt <= 0; done_cnt <= 0; stb_low <= 0;
            stall_cyc <= 0; wsrc_idx <= 0; stall_seen <= 0;
            rd_last <= '0; last_status <= 2'b00;
        end else begin
            if (wb_ack_i) begin
                log_adr[beat_cnt % 16] <= wb_adr_o;
                log_cti[beat_cnt % 16] <= wb_cti_o;
                if (wb_we_o) mem[wb_adr_o[5:2]] <= wb_dat_o;
            end
            if (wb_ack_i || wb_err_i) beat_cnt <= beat_cnt + 1;
            if (rdat_valid) begin rd_cnt <= rd_cnt + 1; rd_last <= rdat_data; end
            if (done) begin done_cnt <= done_cnt + 1; last_status <= status; end
            if (wb_cyc_o && !wb_stb_o) stb_low <= stb_low + 1;
            if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i && !wb_rty_i) stall_cyc <= stall_cyc + 1;
            if (wdat_valid && wdat_ready) wsrc_idx <= wsrc_idx + 1;
            if (wb_cyc_o && src_hold) stall_seen <= stall_seen + 1;
        end
    end

    always @(negedge clk) if (err_prev) cyc_after_err <= wb_cyc_o;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [7:0] len);
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_we = we; cmd_adr = adr; cmd_len = len; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int n = 0;
        while (done_cnt == 0 && n < max_cyc) begin @(negedge clk); n++; end
        check(tag, (done_cnt != 0), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_stb", wb_stb_o, 0);
        check("rst_done", done, 0);
        check("rst_wdat_ready", wdat_ready, 0);
        check("rst_rdat_valid", rdat_valid, 0);
        check("rst_status", status, 0);
        check("rst_adr", wb_adr_o, 0);
        check("rst_bte", wb_bte_o, 0);
        wb_rst_i = 1'b0;
        clear_log();

        // single read
        send_cmd(1'b0, 32'h100, 8'd0);
        wait_done("rd1_done", 20);
        check("rd1_count", rd_cnt, 1);
        check("rd1_data", rd_last, 32'hDEADBEEF);
        check("rd1_cti", log_cti[0], 3'b000);
        check("rd1_adr", log_adr[0], 32'h100);
        check("rd1_status", last_status, 2'b00);
        check("rd1_done_once", done_cnt, 1);

        // write burst of 4 words 1..4 at 0x0
        clear_log();
        wsrc_n = 6; wbase = 32'h0; wsrc_on = 1'b1;
        send_cmd(1'b1, 32'h0, 8'd3);
        wait_done("wr_done", 40);
        wsrc_on = 1'b0;
        check("wr_beats", beat_cnt, 4);
        check("wr_adr0", log_adr[0], 32'h0);
        check("wr_adr1", log_adr[1], 32'h4);
        check("wr_adr2", log_adr[2], 32'h8);
        check("wr_adr3", log_adr[3], 32'hC);
        check("wr_cti0", log_cti[0], 3'b010);
        check("wr_cti1", log_cti[1], 3'b010);
        check("wr_cti2", log_cti[2], 3'b010);
        check("wr_cti3", log_cti[3], 3'b111);
        check("wr_mem0", mem[0], 32'd1);
        check("wr_mem1", mem[1], 32'd2);
        check("wr_mem2", mem[2], 32'd3);
        check("wr_mem3", mem[3], 32'd4);
        check("wr_consumed", wsrc_idx, 4);
        check("wr_stb_low", stb_low, 1);
        check("wr_status", last_status, 2'b00);

        // write burst with source stalled 3 cycles before beat 2
        clear_log();
        wsrc_n = 4; wbase = 32'h10; stall_at = 2; stall_len = 3; wsrc_on = 1'b1;
        send_cmd(1'b1, 32'h10, 8'd3);
        wait_done("wst_done", 40);
        wsrc_on = 1'b0; stall_at = -1;
        check("wst_beats", beat_cnt, 4);
        check("wst_stb_low", stb_low, 4);
        check("wst_mem4", mem[4], 32'h11);
        check("wst_mem6", mem[6], 32'h13);
        check("wst_mem7", mem[7], 32'h14);

        // read burst of 8 with err on beat 2
        clear_log();
        err_mode = 1'b1; err_beat = 2;
        send_cmd(1'b0, 32'h20, 8'd7);
        wait_done("err_done", 30);
        err_mode = 1'b0;
        check("err_rd_count", rd_cnt, 2);
        check("err_rd_last", rd_last, 32'hA5A5_0024);
        check("err_cyc_next", cyc_after_err, 0);
        check("err_status", last_status, 2'b01);

        // retry on single read
        clear_log();
        rty_mode = 1'b1;
        send_cmd(1'b0, 32'h100, 8'd0);
        wait_done("rty_done", 20);
        rty_mode = 1'b0;
        check("rty_rd_count", rd_cnt, 0);
        check("rty_status", last_status, 2'b10);

        // unresponsive slave
        clear_log();
        slv_en = 1'b0;
        send_cmd(1'b0, 32'h40, 8'd0);
`ifdef WB_BURST_MASTER_TIMEOUT_EN
        wait_done("to_done", 60);
        check("to_status", last_status, 2'b11);
        check("to_stall_cycles", stall_cyc, 16);
        check("to_cyc_low", wb_cyc_o, 0);
`else
        repeat (60) @(negedge clk);
        check("noto_cyc_held", wb_cyc_o, 1);
        check("noto_no_done", done_cnt, 0);
        wb_rst_i = 1'b1;
        @(negedge clk);
        wb_rst_i = 1'b0;
`endif
        slv_en = 1'b1;

        // reset in the middle of a read burst, at beat 3
        clear_log();
        send_cmd(1'b0, 32'h40, 8'd7);
        begin
            int n = 0;
            while (beat_cnt != 3 && n < 20) begin @(negedge clk); n++; end
            check("mid_reach_beat3", beat_cnt, 3);
        end
        wb_rst_i = 1'b1;
        @(negedge clk);
        check("mid_cyc", wb_cyc_o, 0);
        check("mid_stb", wb_stb_o, 0);
        check("mid_cmd_ready", cmd_ready, 1);
        check("mid_done", done, 0);
        wb_rst_i = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_no_done", done_cnt, 0);
        check("mid_idle_cyc", wb_cyc_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 The block SHALL have parameter dw, default 32, Wishbone data width (multiple of 8).
REQ-002 The block SHALL have parameter aw, default 32, Wishbone address width.
REQ-003 The block SHALL have parameter LW, default 8, width of cmd_len.
REQ-004 The block SHALL have parameter TIMEOUT, default 256, watchdog limit in cycles.
REQ-005 wb_clk_i  in  1  clock, the only clock; all logic on its rising edge.
REQ-006 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-007 cmd_valid in 1 / cmd_ready out 1  command handshake.
REQ-008 cmd_we in 1, write (1) or read (0); cmd_adr in aw, byte start address; cmd_len in LW, beats minus one.
REQ-009 wdat_valid in 1 / wdat_ready out 1 / wdat_data in dw / wdat_sel in dw/8  write-data stream.
REQ-010 rdat_valid out 1 / rdat_data out dw  read-data stream, no backpressure.
REQ-011 done out 1, one-cycle completion pulse; status out 2, 00 ok, 01 err, 10 rty, 11 timeout.
REQ-012 wb_adr_o aw, wb_dat_o dw, wb_sel_o dw/8, wb_we_o 1, wb_cti_o 3, wb_bte_o 2, wb_cyc_o 1, wb_stb_o 1  out, Wishbone master.
REQ-013 wb_dat_i dw, wb_ack_i 1, wb_err_i 1, wb_rty_i 1  in, Wishbone master.

Function
REQ-014 FSM states SHALL be IDLE, BUS, DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-015 Command accept (cmd_valid & cmd_ready) SHALL latch cmd_*, load beat counter = cmd_len, and enter BUS with wb_cyc_o=1 on the next cycle.
REQ-016 wb_cyc_o SHALL stay 1 for the whole command; wb_stb_o SHALL be 1 in BUS for reads, and for writes only while a beat is loaded.
REQ-017 Writes: wdat_ready SHALL be 1 in BUS when no beat is loaded or the loaded beat is acked this cycle; the accepted wdat_data/wdat_sel SHALL drive wb_dat_o/wb_sel_o from the next cycle.
REQ-018 Reads: wb_sel_o SHALL be all ones; each wb_ack_i SHALL produce rdat_valid=1 with rdat_data=wb_dat_i in that same cycle.
REQ-019 wb_adr_o SHALL advance by dw/8 per ack, modulo 2^aw; wb_bte_o SHALL be 00 always.
REQ-020 wb_cti_o SHALL be 000 when cmd_len=0, 010 on non-final burst beats, 111 on the final beat.
REQ-021 Ack of the final beat SHALL enter DONE; DONE SHALL drop cyc/stb, pulse done=1 with status=00 for one cycle, and return to IDLE.
REQ-022 wb_err_i or wb_rty_i in BUS SHALL abort remaining beats and enter DONE with status 01 or 10; err takes priority over rty, rty over ack.
REQ-023 Write data offered while wdat_ready=0 SHALL not be consumed; unused write beats after abort SHALL remain in the source.

Reset
REQ-024 Reset SHALL force IDLE and all outputs to 0 except cmd_ready=1, overriding any cycle in progress; wb_cyc_o SHALL be 0 the cycle after reset is sampled.

Configuration
REQ-025 With WB_BURST_MASTER_TIMEOUT_EN defined, TIMEOUT consecutive BUS cycles with stb=1 and no ack/err/rty SHALL abort to DONE with status 11.
REQ-026 Without WB_BURST_MASTER_TIMEOUT_EN the watchdog SHALL be absent and the master SHALL wait indefinitely; status 11 never occurs.

Structure
REQ-027 CTI codes (000, 010, 111), BTE codes and status codes SHALL live in the shared package wb_common_pkg.
REQ-028 The watchdog SHALL be the sub-module wb_watchdog (counter, clear, expire), instantiated only under the macro.

Verification
REQ-029 Single read: cmd_adr=0x100, cmd_len=0, slave acks with 0xDEADBEEF -> cti=000, one rdat_valid with 0xDEADBEEF, done with status=00.
REQ-030 Write burst: cmd_adr=0x0, cmd_len=3, four words 1..4 -> adr 0x0,0x4,0x8,0xC; cti 010,010,010,111; memory holds 1..4.
REQ-031 Write stall: wdat_valid low for 3 cycles before beat 2 -> stb low for those 3 cycles, cyc held 1, no spurious beat.
REQ-032 Error: err on beat 2 of cmd_len=7 read -> 2 rdat_valid total, cyc low next cycle, done with status=01.
REQ-033 Timeout (macro on, TIMEOUT=16): slave never responds -> done with status=11 after 16 stalled cycles; macro off -> cyc stays 1.
REQ-034 Reset mid-burst at beat 3 -> cyc/stb 0 next cycle, cmd_ready=1, no done pulse.
